// File: rtl/spsram_port_arb_if.sv
// Requester-side port of the shared single-port SRAM arbiter.
// The requester drives the access; the arbiter answers with grant and read return.
interface spsram_port_arb_if #(
    parameter int AW  = 14,
    parameter int DW  = 128,
    parameter int BEW = DW / 8
);
    logic           req;
    logic           lock;
    logic           wen;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  wdata;
    logic [BEW-1:0] wstrb;
    logic           gnt;
    logic           rvalid;
    logic [DW-1:0]  rdata;

    modport master (
        output req, lock, wen, addr, wdata, wstrb,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, lock, wen, addr, wdata, wstrb,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/spsram_port_arb.sv
// Two-port round-robin arbiter in front of the single-port program/data SRAM.
// Requester 0 is the CPU AXI slave, requester 1 the loader/debug backdoor.
// One access per cycle; a locking requester may keep the port for up to
// MAX_HOLD consecutive grants before the other side is served.
module spsram_port_arb #(
    parameter int AW       = 14,
    parameter int DW       = 128,
    parameter int BEW      = DW / 8,
    parameter int MAX_HOLD = 16
) (
    input  logic              clk,
    input  logic              rst_b,
    spsram_port_arb_if.slave  r0,
    spsram_port_arb_if.slave  r1,
    output logic              mem_cen_b,
    output logic              mem_gwen_b,
    output logic [DW-1:0]     mem_wen_b,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_din,
    input  logic [DW-1:0]     mem_dout
);

    localparam int HW = $clog2(MAX_HOLD + 1);

    // Both requesters flattened into packed arrays so arbitration can index by id.
    logic [1:0]          req;
    logic [1:0]          lock;
    logic [1:0]          wen;
    logic [1:0][AW-1:0]  addr;
    logic [1:0][DW-1:0]  wdata;
    logic [1:0][BEW-1:0] wstrb;

    assign req   = {r1.req,   r0.req};
    assign lock  = {r1.lock,  r0.lock};
    assign wen   = {r1.wen,   r0.wen};
    assign addr  = {r1.addr,  r0.addr};
    assign wdata = {r1.wdata, r0.wdata};
    assign wstrb = {r1.wstrb, r0.wstrb};

    logic          owner;      // last granted requester
    logic [HW-1:0] hold_cnt;   // consecutive locked grants to owner
    logic [1:0]    rd_pend;    // read issued last cycle, per requester

    logic          own_keep;
    logic          pri;
    logic [1:0]    gnt;
    logic          gnt_any;
    logic          sel;
    logic [HW-1:0] hold_nxt;

    // Pick the priority requester, then grant it or fall back to the other one.
    always_comb begin
        own_keep = req[owner] & lock[owner] & (hold_cnt < HW'(MAX_HOLD));
        pri      = own_keep ? owner : ~owner;
        gnt      = 2'b00;
        if (req[pri])
            gnt[pri] = 1'b1;
        else if (req[~pri])
            gnt[~pri] = 1'b1;
    end

    assign gnt_any = |gnt;
    assign sel     = gnt[1];

    // Burst length bookkeeping: extend the run only for a locked re-grant to the owner.
    always_comb begin
        hold_nxt = '0;
        if ((sel == owner) && lock[sel])
            hold_nxt = (hold_cnt == HW'(MAX_HOLD)) ? hold_cnt : hold_cnt + HW'(1);
        else if (lock[sel])
            hold_nxt = HW'(1);
    end

    // Arbitration state and read-return tags.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            owner    <= 1'b1;
            hold_cnt <= '0;
            rd_pend  <= 2'b00;
        end else begin
            if (gnt_any) begin
                owner    <= sel;
                hold_cnt <= hold_nxt;
            end
            rd_pend <= gnt & ~wen;
        end
    end

    // SRAM control/address/data: idle values unless someone holds the grant.
    always_comb begin
        mem_cen_b  = 1'b1;
        mem_gwen_b = 1'b1;
        mem_addr   = '0;
        mem_din    = '0;
        if (gnt_any) begin
            mem_cen_b  = 1'b0;
            mem_gwen_b = ~wen[sel];
            mem_addr   = addr[sel];
            mem_din    = wdata[sel];
        end
    end

    // Byte strobes expand to the macro's active-low bit mask; reads mask everything.
    for (genvar b = 0; b < BEW; b++) begin : g_mask
        assign mem_wen_b[8*b +: 8] = {8{~(gnt_any & wen[sel] & wstrb[sel][b])}};
    end

    assign r0.gnt    = gnt[0];
    assign r1.gnt    = gnt[1];
    assign r0.rvalid = rd_pend[0];
    assign r1.rvalid = rd_pend[1];
    assign r0.rdata  = mem_dout & {DW{rd_pend[0]}};
    assign r1.rdata  = mem_dout & {DW{rd_pend[1]}};

endmodule

// File: tb/tb_spsram_port_arb.sv
// Bench for spsram_port_arb: directed scenarios plus a randomized run checked
// against a grant-history reference model and a byte-level memory image.
module tb_spsram_port_arb;
    localparam int AW       = 14;
    localparam int DW       = 128;
    localparam int BEW      = DW / 8;
    localparam int MAX_HOLD = 16;

    logic clk = 1'b0;
    logic rst_b = 1'b0;
    always #5 clk = ~clk;

    spsram_port_arb_if #(.AW(AW), .DW(DW)) p0 ();
    spsram_port_arb_if #(.AW(AW), .DW(DW)) p1 ();

    logic          mem_cen_b;
    logic          mem_gwen_b;
    logic [DW-1:0] mem_wen_b;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;

    spsram_port_arb #(.AW(AW), .DW(DW), .BEW(BEW), .MAX_HOLD(MAX_HOLD)) dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .r0         (p0),
        .r1         (p1),
        .mem_cen_b  (mem_cen_b),
        .mem_gwen_b (mem_gwen_b),
        .mem_wen_b  (mem_wen_b),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout)
    );

    // Behavioural SRAM macro driven purely from the DUT pins.
    logic [DW-1:0] sram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (!mem_cen_b) begin
            if (!mem_gwen_b)
                sram[mem_addr] <= (sram[mem_addr] & mem_wen_b) | (mem_din & ~mem_wen_b);
            else
                mem_dout <= sram[mem_addr];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic set_port(input int k, input logic rq, input logic lk, input logic we,
                            input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [BEW-1:0] s);
        if (k == 0) begin
            p0.req = rq; p0.lock = lk; p0.wen = we; p0.addr = a; p0.wdata = d; p0.wstrb = s;
        end else begin
            p1.req = rq; p1.lock = lk; p1.wen = we; p1.addr = a; p1.wdata = d; p1.wstrb = s;
        end
    endtask

    task automatic idle_all();
        set_port(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        set_port(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        idle_all();
        rst_b = 1'b0;
        next_cycle();
        next_cycle();
        rst_b = 1'b1;
    endtask

    // Single uncontended full or partial write, used to preload rows.
    task automatic write_row(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic [BEW-1:0] s);
        set_port(k, 1'b1, 1'b0, 1'b1, a, d, s);
        next_cycle();
        idle_all();
    endtask

    task automatic test_reset();
        idle_all();
        rst_b = 1'b0;
        @(negedge clk);
        checks++; if (p0.gnt !== 1'b0) begin errors++; $display("FAIL rst_gnt0 got %b exp 0", p0.gnt); end
        checks++; if (p1.gnt !== 1'b0) begin errors++; $display("FAIL rst_gnt1 got %b exp 0", p1.gnt); end
        checks++; if (p0.rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid0 got %b exp 0", p0.rvalid); end
        checks++; if (p1.rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid1 got %b exp 0", p1.rvalid); end
        checks++; if (p0.rdata !== '0) begin errors++; $display("FAIL rst_rdata0 got %h exp 0", p0.rdata); end
        checks++; if (mem_cen_b !== 1'b1) begin errors++; $display("FAIL rst_cen got %b exp 1", mem_cen_b); end
        checks++; if (mem_gwen_b !== 1'b1) begin errors++; $display("FAIL rst_gwen got %b exp 1", mem_gwen_b); end
        checks++; if (mem_wen_b !== {DW{1'b1}}) begin errors++; $display("FAIL rst_wen got %h exp all ones", mem_wen_b); end
        next_cycle();
        rst_b = 1'b1;
    endtask

    task automatic test_read_basic();
        apply_reset();
        write_row(0, 14'h0010, {16{8'hA5}}, '1);
        set_port(0, 1'b1, 1'b0, 1'b0, 14'h0010, '0, '0);
        @(negedge clk);
        checks++; if (p0.gnt !== 1'b1) begin errors++; $display("FAIL rd_gnt0 got %b exp 1", p0.gnt); end
        checks++; if (p1.gnt !== 1'b0) begin errors++; $display("FAIL rd_gnt1 got %b exp 0", p1.gnt); end
        checks++; if (mem_cen_b !== 1'b0) begin errors++; $display("FAIL rd_cen got %b exp 0", mem_cen_b); end
        checks++; if (mem_gwen_b !== 1'b1) begin errors++; $display("FAIL rd_gwen got %b exp 1", mem_gwen_b); end
        checks++; if (mem_addr !== 14'h0010) begin errors++; $display("FAIL rd_addr got %h exp 0010", mem_addr); end
        next_cycle();
        idle_all();
        @(negedge clk);
        checks++; if (p0.rvalid !== 1'b1) begin errors++; $display("FAIL rd_rvalid0 got %b exp 1", p0.rvalid); end
        checks++; if (p0.rdata !== {16{8'hA5}}) begin errors++; $display("FAIL rd_rdata0 got %h exp a5..a5", p0.rdata); end
        checks++; if (p1.rvalid !== 1'b0) begin errors++; $display("FAIL rd_rvalid1 got %b exp 0", p1.rvalid); end
        checks++; if (p1.rdata !== '0) begin errors++; $display("FAIL rd_rdata1 got %h exp 0", p1.rdata); end
        next_cycle();
    endtask

    task automatic test_alternate();
        logic e0;
        apply_reset();
        set_port(0, 1'b1, 1'b0, 1'b0, 14'h0003, '0, '0);
        set_port(1, 1'b1, 1'b0, 1'b0, 14'h0004, '0, '0);
        for (int c = 0; c < 6; c++) begin
            e0 = (c % 2 == 0);
            @(negedge clk);
            checks++; if (p0.gnt !== e0) begin errors++; $display("FAIL alt_gnt0 c=%0d got %b exp %b", c, p0.gnt, e0); end
            checks++; if (p1.gnt !== ~e0) begin errors++; $display("FAIL alt_gnt1 c=%0d got %b exp %b", c, p1.gnt, ~e0); end
            next_cycle();
        end
        idle_all();
    endtask

    task automatic test_burst();
        logic e0;
        apply_reset();
        set_port(0, 1'b1, 1'b1, 1'b0, 14'h0005, '0, '0);
        set_port(1, 1'b1, 1'b0, 1'b0, 14'h0006, '0, '0);
        for (int c = 0; c < 20; c++) begin
            e0 = (c != 16);
            @(negedge clk);
            checks++; if (p0.gnt !== e0) begin errors++; $display("FAIL burst_gnt0 c=%0d got %b exp %b", c, p0.gnt, e0); end
            checks++; if (p1.gnt !== ~e0) begin errors++; $display("FAIL burst_gnt1 c=%0d got %b exp %b", c, p1.gnt, ~e0); end
            next_cycle();
        end
        idle_all();
    endtask

    task automatic test_write_mask();
        apply_reset();
        write_row(1, 14'h0020, {16{8'hCC}}, '1);
        set_port(1, 1'b1, 1'b0, 1'b1, 14'h0020, {16{8'h11}}, 16'h00F0);
        @(negedge clk);
        checks++; if (p1.gnt !== 1'b1) begin errors++; $display("FAIL wm_gnt1 got %b exp 1", p1.gnt); end
        checks++; if (mem_gwen_b !== 1'b0) begin errors++; $display("FAIL wm_gwen got %b exp 0", mem_gwen_b); end
        checks++; if (mem_wen_b !== 128'hFFFFFFFF_FFFFFFFF_00000000_FFFFFFFF) begin
            errors++; $display("FAIL wm_mask got %h exp ffffffffffffffff00000000ffffffff", mem_wen_b); end
        checks++; if (mem_din !== {16{8'h11}}) begin errors++; $display("FAIL wm_din got %h exp 11..11", mem_din); end
        next_cycle();
        set_port(1, 1'b1, 1'b0, 1'b0, 14'h0020, '0, '0);
        next_cycle();
        idle_all();
        @(negedge clk);
        checks++; if (p1.rvalid !== 1'b1) begin errors++; $display("FAIL wm_rvalid1 got %b exp 1", p1.rvalid); end
        checks++; if (p1.rdata !== 128'hCCCCCCCC_CCCCCCCC_11111111_CCCCCCCC) begin
            errors++; $display("FAIL wm_readback got %h exp cccccccccccccccc11111111cccccccc", p1.rdata); end
        checks++; if (p0.rvalid !== 1'b0) begin errors++; $display("FAIL wm_rvalid0 got %b exp 0", p0.rvalid); end
        next_cycle();
    endtask

    task automatic test_interleave();
        logic [DW-1:0] v1, v2;
        v1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        v2 = {$urandom, $urandom, $urandom, $urandom};
        write_row(0, 14'h0001, v1, '1);
        write_row(1, 14'h0002, v2, '1);
        set_port(0, 1'b1, 1'b0, 1'b0, 14'h0001, '0, '0);
        @(negedge clk);
        checks++; if (p0.gnt !== 1'b1) begin errors++; $display("FAIL il_gnt0 got %b exp 1", p0.gnt); end
        next_cycle();
        idle_all();
        set_port(1, 1'b1, 1'b0, 1'b0, 14'h0002, '0, '0);
        @(negedge clk);
        checks++; if (p1.gnt !== 1'b1) begin errors++; $display("FAIL il_gnt1 got %b exp 1", p1.gnt); end
        checks++; if (p0.rvalid !== 1'b1) begin errors++; $display("FAIL il_rvalid0 got %b exp 1", p0.rvalid); end
        checks++; if (p0.rdata !== v1) begin errors++; $display("FAIL il_rdata0 got %h exp %h", p0.rdata, v1); end
        checks++; if (p1.rvalid !== 1'b0) begin errors++; $display("FAIL il_rvalid1_early got %b exp 0", p1.rvalid); end
        next_cycle();
        idle_all();
        @(negedge clk);
        checks++; if (p1.rvalid !== 1'b1) begin errors++; $display("FAIL il_rvalid1 got %b exp 1", p1.rvalid); end
        checks++; if (p1.rdata !== v2) begin errors++; $display("FAIL il_rdata1 got %h exp %h", p1.rdata, v2); end
        checks++; if (p0.rvalid !== 1'b0) begin errors++; $display("FAIL il_rvalid0_late got %b exp 0", p0.rvalid); end
        checks++; if (p0.rdata !== '0) begin errors++; $display("FAIL il_rdata0_late got %h exp 0", p0.rdata); end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        set_port(0, 1'b1, 1'b0, 1'b0, 14'h0001, '0, '0);
        set_port(1, 1'b1, 1'b0, 1'b0, 14'h0002, '0, '0);
        next_cycle();
        set_port(0, 1'b1, 1'b0, 1'b0, 14'h0001, '0, '0);
        idle_all();
        set_port(0, 1'b1, 1'b0, 1'b0, 14'h0001, '0, '0);
        @(negedge clk);
        checks++; if (p0.gnt !== 1'b1) begin errors++; $display("FAIL rm_gnt0 got %b exp 1", p0.gnt); end
        next_cycle();
        idle_all();
        rst_b = 1'b0;
        @(negedge clk);
        checks++; if (p0.rvalid !== 1'b0) begin errors++; $display("FAIL rm_rvalid0 got %b exp 0", p0.rvalid); end
        checks++; if (p0.rdata !== '0) begin errors++; $display("FAIL rm_rdata0 got %h exp 0", p0.rdata); end
        checks++; if (mem_cen_b !== 1'b1) begin errors++; $display("FAIL rm_cen got %b exp 1", mem_cen_b); end
        next_cycle();
        rst_b = 1'b1;
        set_port(0, 1'b1, 1'b0, 1'b0, 14'h0001, '0, '0);
        set_port(1, 1'b1, 1'b0, 1'b0, 14'h0002, '0, '0);
        @(negedge clk);
        checks++; if (p0.gnt !== 1'b1) begin errors++; $display("FAIL rm_first_gnt0 got %b exp 1", p0.gnt); end
        checks++; if (p1.gnt !== 1'b0) begin errors++; $display("FAIL rm_first_gnt1 got %b exp 0", p1.gnt); end
        next_cycle();
        idle_all();
    endtask

    // Random traffic on rows 0x100..0x107. Arbitration is predicted from the
    // grant history (who was granted, with or without lock); data from a
    // byte-level image with a known-bytes mask.
    task automatic test_random();
        logic [DW-1:0]  rm [8];
        logic [DW-1:0]  kn [8];
        int             h_who [$];
        bit             h_lock [$];
        bit             pend [2];
        bit             lk [2];
        bit             we [2];
        int             ad [2];
        logic [DW-1:0]  wd [2];
        logic [BEW-1:0] ws [2];
        bit             prv [2];
        logic [DW-1:0]  pdat [2];
        logic [DW-1:0]  pkn [2];
        logic [DW-1:0]  em;
        logic [DW-1:0]  rd;
        logic           rv;
        int last, streak, pri, g;

        for (int i = 0; i < 8; i++) begin rm[i] = '0; kn[i] = '0; end
        for (int k = 0; k < 2; k++) begin pend[k] = 0; prv[k] = 0; pdat[k] = '0; pkn[k] = '0; end
        apply_reset();

        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (!pend[k] && $urandom_range(0, 3) != 0) begin
                    pend[k] = 1;
                    lk[k]   = ($urandom_range(0, 3) != 0);
                    we[k]   = $urandom_range(0, 1);
                    ad[k]   = $urandom_range(0, 7);
                    wd[k]   = {$urandom, $urandom, $urandom, $urandom};
                    ws[k]   = BEW'($urandom);
                end
                set_port(k, pend[k], lk[k], we[k], AW'(14'h0100 + ad[k]), wd[k], ws[k]);
            end

            last = (h_who.size() == 0) ? 1 : h_who[h_who.size()-1];
            streak = 0;
            for (int i = h_who.size() - 1; i >= 0 && streak < MAX_HOLD; i--) begin
                if (h_who[i] == last && h_lock[i]) streak++;
                else break;
            end
            pri = (pend[last] && lk[last] && streak < MAX_HOLD) ? last : 1 - last;
            g = pend[pri] ? pri : (pend[1-pri] ? 1 - pri : -1);

            @(negedge clk);
            checks++; if (p0.gnt !== (g == 0)) begin errors++; $display("FAIL rnd_gnt0 c=%0d got %b exp %b", c, p0.gnt, g == 0); end
            checks++; if (p1.gnt !== (g == 1)) begin errors++; $display("FAIL rnd_gnt1 c=%0d got %b exp %b", c, p1.gnt, g == 1); end
            checks++; if (mem_cen_b !== (g < 0)) begin errors++; $display("FAIL rnd_cen c=%0d got %b exp %b", c, mem_cen_b, g < 0); end
            em = '1;
            if (g >= 0) begin
                for (int b = 0; b < BEW; b++)
                    if (we[g] && ws[g][b]) em[8*b +: 8] = 8'h00;
                checks++; if (mem_addr !== AW'(14'h0100 + ad[g])) begin errors++; $display("FAIL rnd_addr c=%0d got %h exp %h", c, mem_addr, 14'h0100 + ad[g]); end
                checks++; if (mem_gwen_b !== !we[g]) begin errors++; $display("FAIL rnd_gwen c=%0d got %b exp %b", c, mem_gwen_b, !we[g]); end
                checks++; if (mem_din !== wd[g]) begin errors++; $display("FAIL rnd_din c=%0d got %h exp %h", c, mem_din, wd[g]); end
            end else begin
                checks++; if (mem_addr !== '0 || mem_din !== '0 || mem_gwen_b !== 1'b1) begin
                    errors++; $display("FAIL rnd_idle c=%0d addr %h din %h gwen %b exp 0/0/1", c, mem_addr, mem_din, mem_gwen_b); end
            end
            checks++; if (mem_wen_b !== em) begin errors++; $display("FAIL rnd_mask c=%0d got %h exp %h", c, mem_wen_b, em); end
            for (int k = 0; k < 2; k++) begin
                rv = (k == 0) ? p0.rvalid : p1.rvalid;
                rd = (k == 0) ? p0.rdata  : p1.rdata;
                checks++; if (rv !== prv[k]) begin errors++; $display("FAIL rnd_rvalid%0d c=%0d got %b exp %b", k, c, rv, prv[k]); end
                if (prv[k]) begin
                    checks++; if ((rd & pkn[k]) !== (pdat[k] & pkn[k])) begin
                        errors++; $display("FAIL rnd_rdata%0d c=%0d got %h exp %h", k, c, rd & pkn[k], pdat[k] & pkn[k]); end
                end else begin
                    checks++; if (rd !== '0) begin errors++; $display("FAIL rnd_rdata%0d_zero c=%0d got %h exp 0", k, c, rd); end
                end
            end

            for (int k = 0; k < 2; k++) begin
                prv[k] = (g == k) && !we[k];
                if (prv[k]) begin pdat[k] = rm[ad[k]]; pkn[k] = kn[ad[k]]; end
            end
            if (g >= 0) begin
                if (we[g])
                    for (int b = 0; b < BEW; b++)
                        if (ws[g][b]) begin
                            rm[ad[g]][8*b +: 8] = wd[g][8*b +: 8];
                            kn[ad[g]][8*b +: 8] = 8'hFF;
                        end
                h_who.push_back(g);
                h_lock.push_back(lk[g]);
                if (h_who.size() > 40) begin
                    void'(h_who.pop_front());
                    void'(h_lock.pop_front());
                end
                pend[g] = 0;
            end
            next_cycle();
        end
        idle_all();
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_alternate();
        test_burst();
        test_write_mask();
        test_interleave();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
